// File: rtl/enable_generator_pkg.sv
// Shared types and constants for the enable generator sequencer and its compare channels.
package enable_generator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    localparam logic STOP_AT_END    = 1'b0;
    localparam logic STOP_IMMEDIATE = 1'b1;

    // Compare channels only produce pulses while the counter is genuinely counting.
    function automatic logic compare_active(input seq_state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/enable_generator_sequencer_compare.sv
// One compare channel: holds its threshold and emits a registered single-cycle pulse on match.
module enable_compare_unit #(
    parameter int CW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_i,
    input  logic [CW-1:0] thresh_i,
    input  logic [CW-1:0] counter_i,
    input  logic [CW-1:0] period_i,
    input  logic          active_i,
    output logic          pulse_o
);

    logic [CW-1:0] thresh_q;
    logic [CW-1:0] thresh_d;
    logic          pulse_q;
    logic          pulse_d;

    // A threshold at or beyond the period can never be reached, so the channel stays silent.
    always_comb begin
        thresh_d = thresh_q;
        pulse_d  = 1'b0;
        if (load_i) begin
            thresh_d = thresh_i;
        end
        if (active_i && (counter_i == thresh_q) && (thresh_q < period_i)) begin
            pulse_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            thresh_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            thresh_q <= thresh_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/enable_generator_sequencer.sv
// Run controller for one enable_generator_counter: start/stop FSM, cfg handshake, pending shadow.
// Defining ENABLE_GENERATOR_SEQ_IRQ_EN adds the sticky irq output and its irq_clear input.
module enable_generator_sequencer
    import enable_generator_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int N_ENABLES     = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             stop,
    input  logic                             stop_mode,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [COUNTER_WIDTH-1:0]         cfg_period,
    input  logic [N_ENABLES*COUNTER_WIDTH-1:0] cfg_thresh,
    input  logic [COUNTER_WIDTH-1:0]         counter_in,
    output logic                             gen_enable,
    output logic [COUNTER_WIDTH-1:0]         period_out,
    output logic [N_ENABLES-1:0]             enable_out,
    output logic                             running,
    output logic                             cfg_error,
`ifdef ENABLE_GENERATOR_SEQ_IRQ_EN
    output logic                             irq,
    input  logic                             irq_clear,
`endif
    output seq_state_t                       state_dbg
);

    localparam int CW = COUNTER_WIDTH;
    localparam int TW = N_ENABLES * COUNTER_WIDTH;
    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    seq_state_t    state_q, state_d;
    logic [CW-1:0] period_q, period_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] pend_period_q, pend_period_d;
    logic [TW-1:0] pend_thresh_q, pend_thresh_d;
    logic          cfg_error_q, cfg_error_d;

    logic          wrap;
    logic          cfg_xfer;
    logic          thr_load;
    logic [TW-1:0] thr_value;
    logic          cmp_active;

    // Last count of a period; the subtraction is masked off when the period is zero.
    assign wrap     = (state_q != IDLE) && (period_q != '0) && (counter_in == (period_q - ONE));
    assign cfg_xfer = cfg_valid && cfg_ready;

    // cfg handshake: a set transfers on any cycle where cfg_valid and cfg_ready are both high.
    // cfg_ready depends only on state and pending, never on cfg_valid. In IDLE the set is
    // applied next cycle; in ARMED/RUN it is parked in the shadow until the next period wrap.
    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        pend_d        = pend_q;
        pend_period_d = pend_period_q;
        pend_thresh_d = pend_thresh_q;
        cfg_error_d   = cfg_error_q;
        cfg_ready     = 1'b0;
        thr_load      = 1'b0;
        thr_value     = cfg_thresh;

        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (start && (period_q != '0)) begin
                    state_d = ARMED;
                end
            end
            ARMED, RUN: begin
                cfg_ready = !pend_q;
                if (stop) begin
                    state_d = (stop_mode == STOP_IMMEDIATE) ? IDLE : DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if ((stop && (stop_mode == STOP_IMMEDIATE)) || wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wrap && pend_q) begin
            period_d  = pend_period_q;
            thr_load  = 1'b1;
            thr_value = pend_thresh_q;
            pend_d    = 1'b0;
        end

        if (cfg_xfer) begin
            cfg_error_d = 1'b0;
            if (state_q == IDLE) begin
                period_d  = cfg_period;
                thr_load  = 1'b1;
                thr_value = cfg_thresh;
                pend_d    = 1'b0;
            end else begin
                pend_d        = 1'b1;
                pend_period_d = cfg_period;
                pend_thresh_d = cfg_thresh;
            end
        end

        // A refused start reports against the period it saw, even if a new set lands alongside.
        if ((state_q == IDLE) && start && (period_q == '0)) begin
            cfg_error_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            period_q      <= '0;
            pend_q        <= 1'b0;
            pend_period_q <= '0;
            pend_thresh_q <= '0;
            cfg_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            pend_q        <= pend_d;
            pend_period_q <= pend_period_d;
            pend_thresh_q <= pend_thresh_d;
            cfg_error_q   <= cfg_error_d;
        end
    end

    assign cmp_active = compare_active(state_q);

    for (genvar g = 0; g < N_ENABLES; g++) begin : g_cmp
        enable_compare_unit #(
            .CW(CW)
        ) u_cmp (
            .clock    (clock),
            .reset    (reset),
            .load_i   (thr_load),
            .thresh_i (thr_value[g*CW +: CW]),
            .counter_i(counter_in),
            .period_i (period_q),
            .active_i (cmp_active),
            .pulse_o  (enable_out[g])
        );
    end

`ifdef ENABLE_GENERATOR_SEQ_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (irq_clear) begin
            irq_d = 1'b0;
        end
        if ((wrap && (state_q == RUN)) || ((state_q == DRAIN) && (state_d == IDLE))) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    // State is registered, so gen_enable falls the cycle IDLE is entered.
    assign gen_enable = (state_q != IDLE);
    assign running    = (state_q != IDLE);
    assign period_out = period_q;
    assign cfg_error  = cfg_error_q;
    assign state_dbg  = state_q;

endmodule
